// File: rtl/sin_cos_arbiter.sv
// sin_cos_arbiter: shares one in-order, fixed-latency Sin_Cos pipeline among
// N_REQ requesters. Round-robin grant, at most one issue per cycle, and a tag
// FIFO that routes each returning result back to the requester that issued it.
module sin_cos_arbiter #(
    parameter  int N_REQ   = 4,
    parameter  int MAX_OUT = 32,
    localparam int TAG_W   = $clog2(N_REQ),
    localparam int CNT_W   = $clog2(MAX_OUT) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [32*N_REQ-1:0]   i_req_th,
    output logic [N_REQ-1:0]      o_req_ready,
    output logic [N_REQ-1:0]      o_rsp_valid,
    output logic [31:0]           o_rsp_sin,
    output logic [31:0]           o_rsp_cos,
    output logic                  o_sc_ena,
    output logic [31:0]           o_sc_th,
    input  logic [31:0]           i_sc_sin,
    input  logic [31:0]           i_sc_cos,
    input  logic                  i_sc_valid,
    output logic [CNT_W-1:0]      o_outstanding,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int PTR_W = $clog2(MAX_OUT);

    // Arbitration state
    logic [TAG_W-1:0]  ptr_reg;
    logic [CNT_W-1:0]  cnt_reg;

    // Tag FIFO; occupancy always equals cnt_reg, so cnt_reg doubles as the
    // FIFO level and no separate full/empty flags are kept.
    logic [TAG_W-1:0]  tag_mem [MAX_OUT];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;

    // Issue and return registers
    logic              sc_ena_reg;
    logic [31:0]       sc_th_reg;
    logic              rsp_pulse_reg;
    logic [TAG_W-1:0]  rsp_tag_reg;
    logic [31:0]       rsp_sin_reg;
    logic [31:0]       rsp_cos_reg;
    logic              err_reg;

    // Combinational arbitration results
    logic [TAG_W-1:0]  cand_idx [N_REQ];
    logic [N_REQ-1:0]  eligible;
    logic              not_full;
    logic              hs;
    logic [TAG_W-1:0]  grant;
    logic [N_REQ-1:0]  ready_onehot;
    logic [31:0]       grant_th;
    logic              pop;
    logic              underflow;
    logic [N_REQ-1:0]  rsp_onehot;

    // Fullness uses the registered count only: a same-cycle return never
    // frees a slot, which keeps i_sc_valid out of the ready path.
    assign not_full = (cnt_reg < CNT_W'(MAX_OUT));
    assign eligible = i_req_valid & {N_REQ{not_full}};

    // Search order ptr, ptr+1, ... wrapping modulo N_REQ (N_REQ need not be a power of 2)
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        logic [TAG_W:0] sum;
        assign sum          = {1'b0, ptr_reg} + (TAG_W+1)'(gi);
        assign cand_idx[gi] = (sum >= (TAG_W+1)'(N_REQ)) ?
                              TAG_W'(sum - (TAG_W+1)'(N_REQ)) : sum[TAG_W-1:0];
    end

    // Pick the first eligible requester in round-robin order
    always_comb begin
        hs           = 1'b0;
        grant        = '0;
        ready_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!hs && eligible[cand_idx[i]]) begin
                hs    = 1'b1;
                grant = cand_idx[i];
            end
        end
        if (hs) begin
            ready_onehot[grant] = 1'b1;
        end
    end

    assign grant_th  = i_req_th[32*grant +: 32];
    assign pop       = i_sc_valid && (cnt_reg != '0);
    assign underflow = i_sc_valid && (cnt_reg == '0);

    // Round-robin pointer, outstanding count, FIFO pointers and sticky error
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_reg    <= '0;
            cnt_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (hs) begin
                ptr_reg    <= (grant == TAG_W'(N_REQ-1)) ? '0 : grant + TAG_W'(1);
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (hs && !pop) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else if (!hs && pop) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            if (underflow) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Tag storage with registered read; the read lands exactly when the
    // response pulse goes out. Push and pop never share an address: push is
    // blocked when full and pop requires non-empty.
    always_ff @(posedge i_clk) begin
        if (hs) begin
            tag_mem[wr_ptr_reg] <= grant;
        end
        if (pop) begin
            rsp_tag_reg <= tag_mem[rd_ptr_reg];
        end
    end

    // Issue one cycle after handshake; theta holds its last value otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sc_ena_reg <= 1'b0;
            sc_th_reg  <= '0;
        end else begin
            sc_ena_reg <= hs;
            if (hs) begin
                sc_th_reg <= grant_th;
            end
        end
    end

    // Capture returning results; underflow results are dropped entirely
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_pulse_reg <= 1'b0;
            rsp_sin_reg   <= '0;
            rsp_cos_reg   <= '0;
        end else begin
            rsp_pulse_reg <= pop;
            if (pop) begin
                rsp_sin_reg <= i_sc_sin;
                rsp_cos_reg <= i_sc_cos;
            end
        end
    end

    // Decode the returned tag into the one-hot response strobe
    always_comb begin
        rsp_onehot = '0;
        if (rsp_pulse_reg) begin
            rsp_onehot[rsp_tag_reg] = 1'b1;
        end
    end

    assign o_req_ready   = ready_onehot;
    assign o_rsp_valid   = rsp_onehot;
    assign o_rsp_sin     = rsp_sin_reg;
    assign o_rsp_cos     = rsp_cos_reg;
    assign o_sc_ena      = sc_ena_reg;
    assign o_sc_th       = sc_th_reg;
    assign o_outstanding = cnt_reg;
    assign o_busy        = (cnt_reg != '0);
    assign o_err         = err_reg;

endmodule

// File: tb/tb_sin_cos_arbiter.sv
// Bench for sin_cos_arbiter: behavioural Sin_Cos pipeline (latency 20) plus a
// queue-based reference model of grants, in-flight tags and returned results.
module tb_sin_cos_arbiter;

    localparam int N    = 4;
    localparam int MAXO = 8;
    localparam int L    = 20;
    localparam int CW   = $clog2(MAXO) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [32*N-1:0] req_th = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_sin, rsp_cos;
    logic            sc_ena;
    logic [31:0]     sc_th;
    logic [31:0]     sc_sin, sc_cos;
    logic            sc_valid;
    logic [CW-1:0]   outstanding;
    logic            busy, err;

    always #5 clk = ~clk;

    sin_cos_arbiter #(.N_REQ(N), .MAX_OUT(MAXO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_th(req_th), .o_req_ready(req_ready),
        .o_rsp_valid(rsp_valid), .o_rsp_sin(rsp_sin), .o_rsp_cos(rsp_cos),
        .o_sc_ena(sc_ena), .o_sc_th(sc_th),
        .i_sc_sin(sc_sin), .i_sc_cos(sc_cos), .i_sc_valid(sc_valid),
        .o_outstanding(outstanding), .o_busy(busy), .o_err(err)
    );

    // Sin_Cos stand-in: a known function of theta, exact for pi/2
    function automatic logic [31:0] f_sin(input logic [31:0] th);
        if (th == 32'h3FC90FDB) return 32'h3F800000;
        return {th[15:0], th[31:16]} ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] f_cos(input logic [31:0] th);
        if (th == 32'h3FC90FDB) return 32'hB33BBD2E;
        return ~th + 32'd1;
    endfunction

    // Fixed-latency Sin_Cos pipeline; not reset, so in-flight results survive an arbiter reset
    bit        pv [L];
    bit [31:0] pt [L];
    bit        inject = 1'b0;

    always @(posedge clk) begin
        pv[0] <= sc_ena;
        pt[0] <= sc_th;
        for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            pt[i] <= pt[i-1];
        end
    end

    assign sc_valid = pv[L-1] | inject;
    assign sc_sin   = inject ? 32'hDEADBEEF : f_sin(pt[L-1]);
    assign sc_cos   = inject ? 32'hFEEDF00D : f_cos(pt[L-1]);

    // Reference model: queue of in-flight requests in issue order
    typedef struct {
        int          tag;
        logic [31:0] th;
    } req_t;

    req_t        mq[$];
    int          m_ptr;
    bit          m_ena;
    logic [31:0] m_th;
    logic [N-1:0] m_rsp;
    logic [31:0] m_sin, m_cos;
    bit          m_err;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit verbose = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ptr = 0;
        m_ena = 1'b0;
        m_th  = '0;
        m_rsp = '0;
        m_sin = '0;
        m_cos = '0;
        m_err = 1'b0;
    endtask

    task automatic check_regs();
        check("sc_ena",      32'(sc_ena),      32'(m_ena));
        check("sc_th",       sc_th,            m_th);
        check("rsp_valid",   32'(rsp_valid),   32'(m_rsp));
        check("rsp_sin",     rsp_sin,          m_sin);
        check("rsp_cos",     rsp_cos,          m_cos);
        check("outstanding", 32'(outstanding), 32'(mq.size()));
        check("busy",        32'(busy),        32'(mq.size() != 0));
        check("err",         32'(err),         32'(m_err));
    endtask

    // One clock cycle: check registered outputs, drive inputs, check ready, advance model
    task automatic step(input logic [N-1:0] v, input bit inj, input logic [31:0] fth);
        int           g;
        logic [N-1:0] er;
        logic [31:0]  gth;
        req_t         h;
        check_regs();
        req_valid = v;
        for (int k = 0; k < N; k++) begin
            req_th[32*k +: 32] = (fth != 0) ? fth : $urandom();
        end
        inject = inj;
        #1;
        g  = -1;
        er = '0;
        if (mq.size() < MAXO) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(er));
        m_rsp = '0;
        if (sc_valid) begin
            if (mq.size() > 0) begin
                h        = mq.pop_front();
                m_rsp[h.tag] = 1'b1;
                m_sin    = f_sin(h.th);
                m_cos    = f_cos(h.th);
                if (verbose) $display("return  k=%0d th=%h cycle %0d", h.tag, h.th, cyc);
            end else begin
                m_err = 1'b1;
                if (verbose) $display("stray   return dropped cycle %0d", cyc);
            end
        end
        if (g >= 0) begin
            gth   = req_th[32*g +: 32];
            mq.push_back('{tag: g, th: gth});
            m_ptr = (g + 1) % N;
            m_ena = 1'b1;
            m_th  = gth;
            if (verbose) $display("issue   k=%0d th=%h cycle %0d", g, gth, cyc);
        end else begin
            m_ena = 1'b0;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        req_valid = '0;
        inject    = 1'b0;
        rst_n     = 1'b0;
        #1;
        model_reset();
        check_regs();
        check("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, 32'd0);
    endtask

    initial begin
        int c0, lat;
        model_reset();
        @(negedge clk);
        do_reset();

        // 1: single request, check end-to-end latency and pi/2 result
        c0  = cyc;
        step(4'b0100, 1'b0, 32'h3FC90FDB);
        lat = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            if (rsp_valid != '0) begin
                lat = cyc - c0;
                check("t1_rsp_valid", 32'(rsp_valid), 32'h4);
                check("t1_sin", rsp_sin, 32'h3F800000);
            end
            step('0, 1'b0, 32'd0);
        end
        check("t1_latency", lat, 32'd22);

        // 2: all requesters valid, round-robin sequence
        for (int i = 0; i < 12; i++) step(4'hF, 1'b0, 32'd0);
        idle(30);

        // 3: single requester saturates the in-flight limit
        for (int i = 0; i < 10; i++) step(4'b0001, 1'b0, 32'd0);
        check("t3_outstanding", 32'(outstanding), MAXO);
        check("t3_ready_low", 32'(req_ready), 32'd0);
        for (int i = 0; i < 25; i++) step(4'b0001, 1'b0, 32'd0);
        idle(30);

        // 4: stray result with nothing in flight
        step('0, 1'b1, 32'd0);
        for (int i = 0; i < 20; i++) step(4'($urandom()), 1'b0, 32'd0);
        idle(30);
        check("t4_err_sticky", 32'(err), 32'd1);

        // 5: reset with results in flight; they come back as strays
        do_reset();
        for (int i = 0; i < 6; i++) step(4'hF, 1'b0, 32'd0);
        step('0, 1'b0, 32'd0);
        do_reset();
        idle(30);
        check("t5_err", 32'(err), 32'd1);
        do_reset();

        // 6: random traffic
        verbose = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] v;
            v = 4'($urandom());
            if ($urandom_range(0, 9) == 0) v = '0;
            if ($urandom_range(0, 19) == 0) v = 4'hF;
            step(v, 1'b0, 32'd0);
        end
        idle(30);
        check("t6_drained", 32'(outstanding), 32'd0);
        check("t6_no_err", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
